// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port directions, flit field positions, route-unit states.
package noc_pkg;

    typedef logic [4:0] port_req_t;

    localparam port_req_t DIR_N    = 5'b00001;
    localparam port_req_t DIR_S    = 5'b00010;
    localparam port_req_t DIR_E    = 5'b00100;
    localparam port_req_t DIR_W    = 5'b01000;
    localparam port_req_t DIR_L    = 5'b10000;
    localparam port_req_t DIR_NONE = 5'b00000;

    // Destination address sits in the low byte of every flit.
    localparam int unsigned ADDR_LSB = 0;
    localparam int unsigned ADDR_MSB = 7;

    // Head and tail markers are the two top bits, whatever the flit width.
    function automatic int unsigned head_bit(input int unsigned flit_w);
        return flit_w - 1;
    endfunction

    function automatic int unsigned tail_bit(input int unsigned flit_w);
        return flit_w - 2;
    endfunction

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ROUTED = 2'd1;
    localparam logic [1:0] ST_DROP   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ROUTED = ST_ROUTED,
        DROP   = ST_DROP
    } rcu_state_e;

endpackage

// File: rtl/route_compute_unit_if.sv
// Per-channel queue/allocator handshake bundle between the input queues, the route unit and the allocator.
interface route_compute_unit_if #(
    parameter int unsigned NUM_IN = 5,
    parameter int unsigned FLIT_W = 16
);
    import noc_pkg::*;

    logic      [NUM_IN-1:0]             valid_i;
    logic      [NUM_IN-1:0][FLIT_W-1:0] flit_i;
    logic      [NUM_IN-1:0]             ready_o;
    port_req_t [NUM_IN-1:0]             req_o;
    logic      [NUM_IN-1:0]             grant_i;
    logic      [NUM_IN-1:0]             err_o;

    modport master (
        output valid_i, flit_i, grant_i,
        input  ready_o, req_o, err_o
    );

    modport slave (
        input  valid_i, flit_i, grant_i,
        output ready_o, req_o, err_o
    );

endinterface

// File: rtl/route_calc.sv
// Dimension-ordered route selection for one destination address against this router's one-hot coordinates.
module route_calc
    import noc_pkg::*;
#(
    parameter int unsigned COORD_W  = 4,
    parameter bit          YX_FIRST = 1'b1
) (
    input  logic [2*COORD_W-1:0] dst,
    input  logic [2*COORD_W-1:0] myaddr,
    output port_req_t            route
);

    logic [COORD_W-1:0] dst_x, dst_y, my_x, my_y;
    port_req_t          y_dir, x_dir;
    logic               addr_ok;

    assign dst_x = dst[2*COORD_W-1:COORD_W];
    assign dst_y = dst[COORD_W-1:0];
    assign my_x  = myaddr[2*COORD_W-1:COORD_W];
    assign my_y  = myaddr[COORD_W-1:0];

    function automatic logic one_hot(input logic [COORD_W-1:0] v);
        return (v != '0) && ((v & (v - COORD_W'(1))) == '0);
    endfunction

    assign addr_ok = one_hot(dst_x) && one_hot(dst_y);

    // One-hot fields compare correctly as plain unsigned numbers.
    always_comb begin
        y_dir = DIR_NONE;
        x_dir = DIR_NONE;
        if (dst_y < my_y)
            y_dir = DIR_S;
        else if (dst_y > my_y)
            y_dir = DIR_N;
        if (dst_x < my_x)
            x_dir = DIR_E;
        else if (dst_x > my_x)
            x_dir = DIR_W;
    end

    always_comb begin
        route = DIR_NONE;
        if (addr_ok) begin
            if (YX_FIRST)
                route = (y_dir != DIR_NONE) ? y_dir : ((x_dir != DIR_NONE) ? x_dir : DIR_L);
            else
                route = (x_dir != DIR_NONE) ? x_dir : ((y_dir != DIR_NONE) ? y_dir : DIR_L);
        end
    end

endmodule

// File: rtl/route_compute_unit.sv
// Per-channel route latching for one mesh router: holds each packet's port request until its tail pops,
// drains packets with malformed addresses and counts them.
module route_compute_unit
    import noc_pkg::*;
#(
    parameter int unsigned NUM_IN   = 5,
    parameter int unsigned FLIT_W   = 16,
    parameter int unsigned COORD_W  = 4,
    parameter bit          YX_FIRST = 1'b1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*COORD_W-1:0] myaddr_i,
    route_compute_unit_if.slave  rcu,
    output logic [CNT_W-1:0]     drop_cnt_o
);

    localparam int unsigned AW    = 2 * COORD_W;
    localparam int unsigned HB    = head_bit(FLIT_W);
    localparam int unsigned TB    = tail_bit(FLIT_W);
    localparam int unsigned SUM_W = $clog2(NUM_IN + 1);
    localparam int unsigned CW1   = CNT_W + 1;

    rcu_state_e              state_q [NUM_IN];
    rcu_state_e              state_d [NUM_IN];
    port_req_t [NUM_IN-1:0]  req_q, req_d;
    port_req_t               route   [NUM_IN];
    logic      [NUM_IN-1:0]  ready, err, drop_done;
    logic      [SUM_W-1:0]   drop_sum;
    logic      [CW1-1:0]     cnt_sum;
    logic      [CNT_W-1:0]   cnt_q, cnt_d;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_route
        route_calc #(
            .COORD_W  (COORD_W),
            .YX_FIRST (YX_FIRST)
        ) u_route_calc (
            .dst    (rcu.flit_i[g][ADDR_LSB +: AW]),
            .myaddr (myaddr_i),
            .route  (route[g])
        );
    end

    always_comb begin
        req_d     = req_q;
        ready     = '0;
        err       = '0;
        drop_done = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                IDLE: begin
                    if (rcu.valid_i[i]) begin
                        if (rcu.flit_i[i][HB]) begin
                            // Head stays queued; it is popped later under the chosen policy.
                            if (route[i] != DIR_NONE) begin
                                state_d[i] = ROUTED;
                                req_d[i]   = route[i];
                            end else begin
                                state_d[i] = DROP;
                            end
                        end else begin
                            ready[i] = 1'b1;
                            err[i]   = 1'b1;
                        end
                    end
                end
                ROUTED: begin
                    if (rcu.valid_i[i] && rcu.grant_i[i]) begin
                        ready[i] = 1'b1;
                        if (rcu.flit_i[i][TB]) begin
                            state_d[i] = IDLE;
                            req_d[i]   = DIR_NONE;
                        end
                    end
                end
                DROP: begin
                    if (rcu.valid_i[i]) begin
                        ready[i] = 1'b1;
                        if (rcu.flit_i[i][TB]) begin
                            err[i]       = 1'b1;
                            drop_done[i] = 1'b1;
                            state_d[i]   = IDLE;
                        end
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    req_d[i]   = DIR_NONE;
                end
            endcase
        end
    end

    // Several channels may finish a drop in the same cycle; add them all, then clamp.
    always_comb begin
        drop_sum = '0;
        for (int unsigned i = 0; i < NUM_IN; i++)
            drop_sum = drop_sum + SUM_W'(drop_done[i]);
        cnt_sum = {1'b0, cnt_q} + CW1'(drop_sum);
        cnt_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_IN; i++)
                state_q[i] <= IDLE;
            req_q <= '0;
            cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_IN; i++)
                state_q[i] <= state_d[i];
            req_q <= req_d;
            cnt_q <= cnt_d;
        end
    end

    assign rcu.ready_o = rst ? '0 : ready;
    assign rcu.err_o   = rst ? '0 : err;
    assign rcu.req_o   = req_q;
    assign drop_cnt_o  = cnt_q;

endmodule

// File: tb/tb_route_compute_unit.sv
// Self-checking bench for route_compute_unit: directed scenarios plus randomized multi-channel traffic
// checked against a packet-level reference model.
module tb_route_compute_unit;
    import noc_pkg::*;

    localparam int unsigned NUM_IN = 5;
    localparam int unsigned FLIT_W = 16;
    localparam int unsigned CNT_W  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       myaddr = 8'h22;
    logic [CNT_W-1:0] drop_cnt0, drop_cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    route_compute_unit_if #(.NUM_IN(NUM_IN), .FLIT_W(FLIT_W)) bus0 ();
    route_compute_unit_if #(.NUM_IN(NUM_IN), .FLIT_W(FLIT_W)) bus1 ();

    route_compute_unit #(
        .NUM_IN(NUM_IN), .FLIT_W(FLIT_W), .COORD_W(4), .YX_FIRST(1'b1), .CNT_W(CNT_W)
    ) dut0 (
        .clk(clk), .rst(rst), .myaddr_i(myaddr), .rcu(bus0), .drop_cnt_o(drop_cnt0)
    );

    route_compute_unit #(
        .NUM_IN(NUM_IN), .FLIT_W(FLIT_W), .COORD_W(4), .YX_FIRST(1'b0), .CNT_W(CNT_W)
    ) dut1 (
        .clk(clk), .rst(rst), .myaddr_i(myaddr), .rcu(bus1), .drop_cnt_o(drop_cnt1)
    );

    logic [FLIT_W-1:0] q [NUM_IN][$];

    function automatic logic [FLIT_W-1:0] mk_flit(input bit head, input bit tail, input logic [7:0] dst);
        return {head, tail, 6'b0, dst};
    endfunction

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    // Reference route from coordinate indices: y/x differences decide the output port.
    function automatic port_req_t model_route(input logic [7:0] dst, input logic [7:0] me, input bit yx);
        int dx, dy, mx, my;
        port_req_t yd, xd;
        if ($countones(dst[7:4]) != 1 || $countones(dst[3:0]) != 1) return 5'b00000;
        dx = oh_idx(dst[7:4]); dy = oh_idx(dst[3:0]);
        mx = oh_idx(me[7:4]);  my = oh_idx(me[3:0]);
        yd = (dy < my) ? 5'b00010 : ((dy > my) ? 5'b00001 : 5'b00000);
        xd = (dx < mx) ? 5'b00100 : ((dx > mx) ? 5'b01000 : 5'b00000);
        if (yx) return (yd != 0) ? yd : ((xd != 0) ? xd : 5'b10000);
        return (xd != 0) ? xd : ((yd != 0) ? yd : 5'b10000);
    endfunction

    function automatic logic [7:0] rand_good_addr();
        logic [3:0] x, y;
        x = 4'b0001 << $urandom_range(0, 3);
        y = 4'b0001 << $urandom_range(0, 3);
        return {x, y};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus0.valid_i = '0; bus0.flit_i = '0; bus0.grant_i = '0;
        bus1.valid_i = '0; bus1.flit_i = '0; bus1.grant_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus0.valid_i = '1;
        for (int i = 0; i < NUM_IN; i++) bus0.flit_i[i] = mk_flit(0, 0, 8'h22);
        bus0.grant_i = '1;
        tick(); tick();
        #1;
        n_checks++; if (bus0.ready_o !== 5'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 00000", bus0.ready_o); end
        n_checks++; if (bus0.err_o !== 5'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 00000", bus0.err_o); end
        n_checks++; if (bus0.req_o !== '0) begin n_fail++; $display("FAIL reset_req: got %h expected 0", bus0.req_o); end
        n_checks++; if (drop_cnt0 !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", drop_cnt0); end
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_routes();
        logic [7:0] dsts [5] = '{8'h24, 8'h21, 8'h12, 8'h42, 8'h22};
        port_req_t  exps [5] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
        for (int t = 0; t < 30; t++) begin
            logic [7:0] dst;
            port_req_t  exp;
            int         ch;
            if (t < 5) begin
                dst = dsts[t]; exp = exps[t]; ch = 0;
            end else begin
                dst = ($urandom_range(0, 1) == 0) ? rand_good_addr() : 8'($urandom);
                exp = model_route(dst, myaddr, 1'b1);
                ch  = $urandom_range(0, NUM_IN - 1);
            end
            do_reset();
            bus0.valid_i[ch] = 1'b1;
            bus0.flit_i[ch]  = mk_flit(1, 0, dst);
            #1;
            n_checks++; if (bus0.ready_o[ch] !== 1'b0) begin n_fail++; $display("FAIL route_head_ready: dst %h ch%0d got %b expected 0", dst, ch, bus0.ready_o[ch]); end
            tick();
            n_checks++; if (bus0.req_o[ch] !== exp) begin n_fail++; $display("FAIL route_req: dst %h ch%0d got %b expected %b", dst, ch, bus0.req_o[ch], exp); end
        end
        do_reset();
        bus0.valid_i[0] = 1'b1; bus0.flit_i[0] = mk_flit(1, 0, 8'h44);
        bus1.valid_i[0] = 1'b1; bus1.flit_i[0] = mk_flit(1, 0, 8'h44);
        tick();
        n_checks++; if (bus1.req_o[0] !== 5'b01000) begin n_fail++; $display("FAIL route_xy_first: got %b expected 01000", bus1.req_o[0]); end
        n_checks++; if (bus0.req_o[0] !== 5'b00001) begin n_fail++; $display("FAIL route_yx_first: got %b expected 00001", bus0.req_o[0]); end
        n_checks++; if (drop_cnt1 !== 8'd0) begin n_fail++; $display("FAIL route_xy_cnt: got %0d expected 0", drop_cnt1); end
        idle_inputs();
    endtask

    task automatic test_multi_flit();
        logic [FLIT_W-1:0] f [3];
        f[0] = mk_flit(1, 0, 8'h24); f[1] = mk_flit(0, 0, 8'h55); f[2] = mk_flit(0, 1, 8'hA5);
        do_reset();
        bus0.valid_i[0] = 1'b1; bus0.flit_i[0] = f[0]; bus0.grant_i[0] = 1'b0;
        #1;
        n_checks++; if (bus0.req_o[0] !== 5'b0 || bus0.ready_o[0] !== 1'b0) begin n_fail++; $display("FAIL mf_first: req %b ready %b expected 00000/0", bus0.req_o[0], bus0.ready_o[0]); end
        tick();
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++; if (bus0.req_o[0] !== 5'b00001 || bus0.ready_o[0] !== 1'b0 || bus0.err_o[0] !== 1'b0) begin n_fail++; $display("FAIL mf_wait: cyc %0d req %b ready %b err %b expected 00001/0/0", c, bus0.req_o[0], bus0.ready_o[0], bus0.err_o[0]); end
            tick();
        end
        bus0.grant_i[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus0.flit_i[0] = f[k];
            #1;
            n_checks++; if (bus0.req_o[0] !== 5'b00001 || bus0.ready_o[0] !== 1'b1 || bus0.err_o[0] !== 1'b0) begin n_fail++; $display("FAIL mf_pop: flit %0d req %b ready %b err %b expected 00001/1/0", k, bus0.req_o[0], bus0.ready_o[0], bus0.err_o[0]); end
            tick();
        end
        bus0.valid_i[0] = 1'b0; bus0.grant_i[0] = 1'b0;
        #1;
        n_checks++; if (bus0.req_o[0] !== 5'b0 || bus0.ready_o[0] !== 1'b0) begin n_fail++; $display("FAIL mf_after_tail: req %b ready %b expected 00000/0", bus0.req_o[0], bus0.ready_o[0]); end
        idle_inputs();
    endtask

    task automatic test_drop();
        logic [FLIT_W-1:0] f [3];
        f[0] = mk_flit(1, 0, 8'h23); f[1] = mk_flit(0, 0, 8'h11); f[2] = mk_flit(0, 1, 8'h22);
        do_reset();
        bus0.valid_i[0] = 1'b1; bus0.flit_i[0] = f[0];
        #1;
        n_checks++; if (bus0.ready_o[0] !== 1'b0 || bus0.err_o[0] !== 1'b0) begin n_fail++; $display("FAIL drop_head: ready %b err %b expected 0/0", bus0.ready_o[0], bus0.err_o[0]); end
        tick();
        for (int k = 0; k < 3; k++) begin
            bus0.flit_i[0] = f[k];
            #1;
            n_checks++; if (bus0.ready_o[0] !== 1'b1 || bus0.err_o[0] !== (k == 2) || bus0.req_o[0] !== 5'b0) begin n_fail++; $display("FAIL drop_drain: flit %0d ready %b err %b req %b expected 1/%0d/00000", k, bus0.ready_o[0], bus0.err_o[0], bus0.req_o[0], (k == 2)); end
            tick();
        end
        bus0.valid_i[0] = 1'b0;
        #1;
        n_checks++; if (drop_cnt0 !== 8'd1) begin n_fail++; $display("FAIL drop_count: got %0d expected 1", drop_cnt0); end

        // Saturation: 4 drops on ch0, then 5 channels dropping together each round.
        do_reset();
        bus0.valid_i[0] = 1'b1; bus0.flit_i[0] = mk_flit(1, 1, 8'h33);
        for (int c = 0; c < 8; c++) tick();
        n_checks++; if (drop_cnt0 !== 8'd4) begin n_fail++; $display("FAIL sat_single: got %0d expected 4", drop_cnt0); end
        bus0.valid_i = '1;
        for (int i = 0; i < NUM_IN; i++) bus0.flit_i[i] = mk_flit(1, 1, 8'h33);
        #1;
        n_checks++; if (bus0.ready_o !== 5'b0 || bus0.err_o !== 5'b0) begin n_fail++; $display("FAIL sat_idle: ready %b err %b expected 00000/00000", bus0.ready_o, bus0.err_o); end
        tick();
        n_checks++; if (bus0.ready_o !== 5'b11111 || bus0.err_o !== 5'b11111) begin n_fail++; $display("FAIL sat_multi_err: ready %b err %b expected 11111/11111", bus0.ready_o, bus0.err_o); end
        for (int c = 0; c < 99; c++) tick();
        n_checks++; if (drop_cnt0 !== 8'd254) begin n_fail++; $display("FAIL sat_254: got %0d expected 254", drop_cnt0); end
        tick(); tick();
        n_checks++; if (drop_cnt0 !== 8'hFF) begin n_fail++; $display("FAIL sat_clamp: got %0d expected 255", drop_cnt0); end
        for (int c = 0; c < 20; c++) tick();
        n_checks++; if (drop_cnt0 !== 8'hFF) begin n_fail++; $display("FAIL sat_hold: got %0d expected 255", drop_cnt0); end
        idle_inputs();
    endtask

    task automatic test_orphan();
        do_reset();
        bus0.valid_i[3] = 1'b1; bus0.flit_i[3] = mk_flit(1, 1, 8'h00);
        tick(); tick();
        bus0.valid_i[3] = 1'b0;
        bus0.valid_i[2] = 1'b1; bus0.flit_i[2] = mk_flit(0, 0, 8'h24);
        #1;
        n_checks++; if (bus0.ready_o[2] !== 1'b1 || bus0.err_o[2] !== 1'b1) begin n_fail++; $display("FAIL orphan_pop: ready %b err %b expected 1/1", bus0.ready_o[2], bus0.err_o[2]); end
        tick();
        bus0.valid_i[2] = 1'b0;
        #1;
        n_checks++; if (bus0.req_o[2] !== 5'b0) begin n_fail++; $display("FAIL orphan_req: got %b expected 00000", bus0.req_o[2]); end
        n_checks++; if (drop_cnt0 !== 8'd1) begin n_fail++; $display("FAIL orphan_cnt: got %0d expected 1", drop_cnt0); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus0.valid_i[1] = 1'b1; bus0.flit_i[1] = mk_flit(1, 0, 8'h21); bus0.grant_i[1] = 1'b0;
        tick();
        n_checks++; if (bus0.req_o[1] !== 5'b00010) begin n_fail++; $display("FAIL rmid_req: got %b expected 00010", bus0.req_o[1]); end
        bus0.grant_i[1] = 1'b1;
        tick();
        bus0.flit_i[1] = mk_flit(0, 0, 8'h77);
        rst = 1'b1;
        #1;
        n_checks++; if (bus0.ready_o[1] !== 1'b0 || bus0.err_o[1] !== 1'b0) begin n_fail++; $display("FAIL rmid_gated: ready %b err %b expected 0/0", bus0.ready_o[1], bus0.err_o[1]); end
        tick();
        rst = 1'b0;
        bus0.grant_i[1] = 1'b0;
        #1;
        n_checks++; if (bus0.req_o[1] !== 5'b0) begin n_fail++; $display("FAIL rmid_cleared: got %b expected 00000", bus0.req_o[1]); end
        n_checks++; if (bus0.ready_o[1] !== 1'b1 || bus0.err_o[1] !== 1'b1) begin n_fail++; $display("FAIL rmid_orphan: ready %b err %b expected 1/1", bus0.ready_o[1], bus0.err_o[1]); end
        tick();
        bus0.flit_i[1] = mk_flit(1, 0, 8'h21);
        #1;
        n_checks++; if (bus0.ready_o[1] !== 1'b0) begin n_fail++; $display("FAIL rmid_rehead: ready %b expected 0", bus0.ready_o[1]); end
        tick();
        n_checks++; if (bus0.req_o[1] !== 5'b00010) begin n_fail++; $display("FAIL rmid_reroute: got %b expected 00010", bus0.req_o[1]); end
        idle_inputs();
    endtask

    // Queue-fed traffic on every channel; the model follows each packet from head to tail.
    task automatic run_traffic(input string name, input int npk, input int max_len,
                               input int grant_pct, input int bad_pct, input bit distinct);
        logic [7:0] dirs [5] = '{8'h24, 8'h21, 8'h12, 8'h42, 8'h22};
        int         phase [NUM_IN];
        port_req_t  mroute [NUM_IN];
        int         drops;
        int         cycles;
        bit         busy;
        do_reset();
        drops = 0;
        for (int ch = 0; ch < NUM_IN; ch++) begin
            phase[ch] = 0; mroute[ch] = 5'b0;
            q[ch].delete();
            for (int p = 0; p < npk; p++) begin
                int         len;
                logic [7:0] dst;
                len = $urandom_range(1, max_len);
                if (distinct)                              dst = dirs[(ch + p) % 5];
                else if ($urandom_range(0, 99) < bad_pct)  dst = 8'($urandom);
                else                                       dst = rand_good_addr();
                for (int k = 0; k < len; k++)
                    q[ch].push_back(mk_flit(k == 0, k == len - 1, (k == 0) ? dst : 8'($urandom)));
            end
        end
        cycles = 0;
        busy   = 1'b1;
        while (busy && cycles < 3000) begin
            logic [NUM_IN-1:0] v, g;
            logic [FLIT_W-1:0] f [NUM_IN];
            for (int ch = 0; ch < NUM_IN; ch++) begin
                v[ch] = (q[ch].size() > 0);
                f[ch] = v[ch] ? q[ch][0] : '0;
                g[ch] = ($urandom_range(0, 99) < grant_pct);
                bus0.valid_i[ch] = v[ch]; bus0.flit_i[ch] = f[ch]; bus0.grant_i[ch] = g[ch];
            end
            #1;
            n_checks++; if (drop_cnt0 !== ((drops > 255) ? 8'hFF : 8'(drops))) begin n_fail++; $display("FAIL %s_cnt: cyc %0d got %0d expected %0d", name, cycles, drop_cnt0, drops); end
            for (int ch = 0; ch < NUM_IN; ch++) begin
                bit        head, tail, exp_ready, exp_err;
                port_req_t exp_req;
                head = f[ch][FLIT_W-1]; tail = f[ch][FLIT_W-2];
                exp_req = (phase[ch] == 1) ? mroute[ch] : 5'b0;
                exp_ready = (phase[ch] == 0) ? (v[ch] && !head) : (phase[ch] == 1) ? (v[ch] && g[ch]) : v[ch];
                exp_err   = (phase[ch] == 0) ? (v[ch] && !head) : (phase[ch] == 2) ? (v[ch] && tail) : 1'b0;
                n_checks++; if (bus0.req_o[ch] !== exp_req) begin n_fail++; $display("FAIL %s_req: cyc %0d ch%0d got %b expected %b", name, cycles, ch, bus0.req_o[ch], exp_req); end
                n_checks++; if (bus0.ready_o[ch] !== exp_ready) begin n_fail++; $display("FAIL %s_ready: cyc %0d ch%0d got %b expected %b", name, cycles, ch, bus0.ready_o[ch], exp_ready); end
                n_checks++; if (bus0.err_o[ch] !== exp_err) begin n_fail++; $display("FAIL %s_err: cyc %0d ch%0d got %b expected %b", name, cycles, ch, bus0.err_o[ch], exp_err); end
                if (phase[ch] == 0 && v[ch] && head) begin
                    mroute[ch] = model_route(f[ch][7:0], myaddr, 1'b1);
                    phase[ch]  = (mroute[ch] != 0) ? 1 : 2;
                end else if (phase[ch] != 0 && exp_ready && tail) begin
                    if (phase[ch] == 2) drops++;
                    phase[ch] = 0;
                end
                if (exp_ready) void'(q[ch].pop_front());
            end
            tick();
            cycles++;
            busy = 1'b0;
            for (int ch = 0; ch < NUM_IN; ch++)
                if (q[ch].size() > 0 || phase[ch] != 0) busy = 1'b1;
        end
        n_checks++; if (busy) begin n_fail++; $display("FAIL %s_timeout: still busy after %0d cycles, expected drained", name, cycles); end
        idle_inputs();
        #1;
        n_checks++; if (drop_cnt0 !== ((drops > 255) ? 8'hFF : 8'(drops))) begin n_fail++; $display("FAIL %s_final_cnt: got %0d expected %0d", name, drop_cnt0, drops); end
    endtask

    task automatic test_channels();
        run_traffic("distinct", 5, 3, 50, 0, 1'b1);
        run_traffic("mixed", 8, 4, 40, 25, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_traffic("b2b", 8, 1, 100, 0, 1'b0);
        run_traffic("b2b_bad", 8, 1, 70, 30, 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_routes();
        test_multi_flit();
        test_drop();
        test_orphan();
        test_reset_mid();
        test_channels();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
